// File: rtl/rti_operand_sequencer_if.sv
// Bundle of the operand-write, issue, engine and response signals of the operand sequencer.
// master = core/engine side, slave = sequencer.
interface rti_operand_sequencer_if #(
  parameter int NUM_FPRTI_REGS = 16,
  parameter int TAG_W          = 5
);
  logic                             wr_valid_i;
  logic                             wr_ready_o;
  logic [3:0]                       wr_idx_i;
  logic [31:0]                      wr_data_i;
  logic                             start_valid_i;
  logic                             start_ready_o;
  logic [TAG_W-1:0]                 start_tag_i;
  logic [NUM_FPRTI_REGS-1:0][31:0]  fprti_regs_o;
  logic                             input_valid_o;
  logic [31:0]                      engine_return_i;
  logic                             engine_valid_i;
  logic                             rsp_valid_o;
  logic                             rsp_ready_i;
  logic [31:0]                      rsp_data_o;
  logic [TAG_W-1:0]                 rsp_tag_o;
  logic [1:0]                       rsp_err_o;
  logic                             busy_o;

  modport master (
    output wr_valid_i, wr_idx_i, wr_data_i, start_valid_i, start_tag_i,
           engine_return_i, engine_valid_i, rsp_ready_i,
    input  wr_ready_o, start_ready_o, fprti_regs_o, input_valid_o,
           rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o, busy_o
  );

  modport slave (
    input  wr_valid_i, wr_idx_i, wr_data_i, start_valid_i, start_tag_i,
           engine_return_i, engine_valid_i, rsp_ready_i,
    output wr_ready_o, start_ready_o, fprti_regs_o, input_valid_o,
           rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/rti_operand_sequencer.sv
// Operand collection and issue front-end for the ray-triangle intersection engine:
// gathers FP32 operands, issues them in parallel, and returns the engine result with tag/status.
//
// state | meaning
// IDLE  | accepting operand writes and start commands
// ISSUE | one-cycle input_valid_o pulse to the engine
// WAIT  | waiting for engine result or timeout
// RESP  | holding the response until the core accepts it
module rti_operand_sequencer #(
  parameter int                        NUM_FPRTI_REGS = 16,
  parameter logic [NUM_FPRTI_REGS-1:0] REQ_MASK       = 16'h7FFF,
  parameter int                        TIMEOUT_CYCLES = 1023,
  parameter int                        TAG_W          = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rti_operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_FPRTI_REGS-1:0] SLOT_ONE = NUM_FPRTI_REGS'(1);
  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_INCOMPLETE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

  state_t                          state, state_nxt;
  logic [NUM_FPRTI_REGS-1:0][31:0] slots;
  logic [NUM_FPRTI_REGS-1:0]       mask, mask_wr;
  logic [CNT_W-1:0]                cnt;
  logic [31:0]                     rsp_data;
  logic [TAG_W-1:0]                rsp_tag;
  logic [1:0]                      rsp_err;
  logic                            wr_fire, start_fire, ops_ok, timeout_hit;

  assign wr_fire     = bus.wr_valid_i & bus.wr_ready_o;
  assign start_fire  = bus.start_valid_i & bus.start_ready_o;
  // a write in the start cycle counts toward the completeness check
  assign mask_wr     = mask | (wr_fire ? (SLOT_ONE << bus.wr_idx_i) : '0);
  assign ops_ok      = (mask_wr & REQ_MASK) == REQ_MASK;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_fire) state_nxt = ops_ok ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.engine_valid_i || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready_o    = 1'b0;
    bus.start_ready_o = 1'b0;
    bus.input_valid_o = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.busy_o        = 1'b1;
    case (state)
      S_IDLE: begin
        bus.wr_ready_o    = rst_n;
        bus.start_ready_o = rst_n;
        bus.busy_o        = 1'b0;
      end
      S_ISSUE: bus.input_valid_o = 1'b1;
      S_RESP:  bus.rsp_valid_o   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots    <= '0;
      mask     <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_err  <= ERR_OK;
    end else begin
      if (wr_fire) slots[bus.wr_idx_i] <= bus.wr_data_i;
      case (state)
        S_IDLE: begin
          mask <= mask_wr;
          if (start_fire) begin
            rsp_tag <= bus.start_tag_i;
            if (!ops_ok) begin
              rsp_data <= '0;
              rsp_err  <= ERR_INCOMPLETE;
            end
          end
        end
        S_ISSUE: begin
          mask <= '0;
          cnt  <= '0;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // a valid result in the timeout cycle still wins
          if (bus.engine_valid_i) begin
            rsp_data <= bus.engine_return_i;
            rsp_err  <= ERR_OK;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fprti_regs_o = slots;
  assign bus.rsp_data_o   = rsp_data;
  assign bus.rsp_tag_o    = rsp_tag;
  assign bus.rsp_err_o    = rsp_err;

endmodule
